// File: rtl/mips_defs_pkg.sv
// Encodings shared by the controller, data_memory and the M/W pipeline register.
package mips_defs;

  localparam int LOADSEL_W = 3;

  localparam logic [LOADSEL_W-1:0] LOAD_LW  = 3'd0;
  localparam logic [LOADSEL_W-1:0] LOAD_LBU = 3'd1;
  localparam logic [LOADSEL_W-1:0] LOAD_LB  = 3'd2;
  localparam logic [LOADSEL_W-1:0] LOAD_LHU = 3'd3;
  localparam logic [LOADSEL_W-1:0] LOAD_LH  = 3'd4;

  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_MEM = 2'd1;
  localparam logic [1:0] WDSEL_PC8 = 2'd2;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/load_ext.sv
// Combinational byte/halfword extraction with zero/sign extension of a loaded word.
module load_ext
  import mips_defs::*;
#(
  parameter int LSEL_W = 3
) (
  input  logic [31:0]       memword,
  input  logic [1:0]        addr,
  input  logic [LSEL_W-1:0] loadsel,
  output logic [31:0]       data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = memword[7:0];
    case (addr)
      2'd0: byte_sel = memword[7:0];
      2'd1: byte_sel = memword[15:8];
      2'd2: byte_sel = memword[23:16];
      2'd3: byte_sel = memword[31:24];
      default: byte_sel = memword[7:0];
    endcase
  end

  // addr[0] is ignored: misaligned halfwords trap before reaching W.
  assign half_sel = addr[1] ? memword[31:16] : memword[15:0];

  always_comb begin
    data = memword;
    case (loadsel)
      LSEL_W'(LOAD_LBU): data = {24'd0, byte_sel};
      LSEL_W'(LOAD_LB):  data = {{24{byte_sel[7]}}, byte_sel};
      LSEL_W'(LOAD_LHU): data = {16'd0, half_sel};
      LSEL_W'(LOAD_LH):  data = {{16{half_sel[15]}}, half_sel};
      default:           data = memword;
    endcase
  end

endmodule

// File: rtl/mw_stage.sv
// Memory-to-writeback pipeline register: captures M results, selects load data,
// and drives the GPR write port plus the retired-instruction counter.
module mw_stage #(
  parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
  parameter int          LOADSEL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_w,
  input  logic                 flush_w,
  input  logic                 valid_m,
  input  logic [31:0]          pc_m,
  input  logic [31:0]          alu_m,
  input  logic [31:0]          dm_rdata_m,
  input  logic                 hit_dm_m,
  input  logic [31:0]          br_rdata_m,
  input  logic [LOADSEL_W-1:0] loadsel_m,
  input  logic [1:0]           wdsel_m,
  input  logic                 regwr_m,
  input  logic [4:0]           waddr_m,
  output logic                 valid_w,
  output logic [31:0]          pc_w,
  output logic                 regwr_w,
  output logic [4:0]           waddr_w,
  output logic [31:0]          wdata_w,
  output logic [31:0]          instret_w
);

  logic                 valid_reg;
  logic [31:0]          pc_reg;
  logic [31:0]          alu_reg;
  logic [31:0]          memword_reg;
  logic [LOADSEL_W-1:0] loadsel_reg;
  logic [1:0]           wdsel_reg;
  logic                 regwr_reg;
  logic [4:0]           waddr_reg;
  logic [31:0]          instret_reg;
  logic [31:0]          load_data;

  always_ff @(posedge clk) begin
    if (reset || flush_w) begin
      valid_reg   <= 1'b0;
      pc_reg      <= RESET_PC;
      alu_reg     <= 32'd0;
      memword_reg <= 32'd0;
      loadsel_reg <= '0;
      wdsel_reg   <= 2'd0;
      regwr_reg   <= 1'b0;
      waddr_reg   <= 5'd0;
    end else if (!stall_w) begin
      valid_reg   <= valid_m;
      pc_reg      <= pc_m;
      alu_reg     <= alu_m;
      memword_reg <= hit_dm_m ? dm_rdata_m : br_rdata_m;
      loadsel_reg <= loadsel_m;
      wdsel_reg   <= wdsel_m;
      regwr_reg   <= regwr_m;
      waddr_reg   <= waddr_m;
    end
  end

  // The instruction sitting in W retires even when the incoming one is flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_reg <= 32'd0;
    end else if (valid_reg && !stall_w) begin
      instret_reg <= instret_reg + 32'd1;
    end
  end

  load_ext #(.LSEL_W(LOADSEL_W)) u_load_ext (
    .memword (memword_reg),
    .addr    (alu_reg[1:0]),
    .loadsel (loadsel_reg),
    .data    (load_data)
  );

  always_comb begin
    wdata_w = alu_reg;
    case (wdsel_reg)
      mips_defs::WDSEL_MEM: wdata_w = load_data;
      mips_defs::WDSEL_PC8: wdata_w = pc_reg + 32'd8;
      default:              wdata_w = alu_reg;
    endcase
  end

  assign valid_w   = valid_reg;
  assign pc_w      = pc_reg;
  assign regwr_w   = valid_reg && regwr_reg && (waddr_reg != 5'd0);
  assign waddr_w   = waddr_reg;
  assign instret_w = instret_reg;

endmodule

// File: tb/tb_mw_stage.sv
// Directed bench for mw_stage: load extraction, jal link, stall/flush, counter wrap.
module tb_mw_stage;

  logic        clk = 1'b0;
  logic        reset, stall_w, flush_w, valid_m, hit_dm_m, regwr_m;
  logic [31:0] pc_m, alu_m, dm_rdata_m, br_rdata_m;
  logic [2:0]  loadsel_m;
  logic [1:0]  wdsel_m;
  logic [4:0]  waddr_m;
  logic        valid_w, regwr_w;
  logic [31:0] pc_w, wdata_w, instret_w;
  logic [4:0]  waddr_w;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] hold_pc, hold_wdata, hold_instret;
  logic [4:0]  hold_waddr;

  always #5 clk = ~clk;

  mw_stage dut (
    .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
    .valid_m(valid_m), .pc_m(pc_m), .alu_m(alu_m), .dm_rdata_m(dm_rdata_m),
    .hit_dm_m(hit_dm_m), .br_rdata_m(br_rdata_m), .loadsel_m(loadsel_m),
    .wdsel_m(wdsel_m), .regwr_m(regwr_m), .waddr_m(waddr_m),
    .valid_w(valid_w), .pc_w(pc_w), .regwr_w(regwr_w), .waddr_w(waddr_w),
    .wdata_w(wdata_w), .instret_w(instret_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dm, input logic hit, input logic [31:0] br,
                       input logic [2:0] ls, input logic [1:0] wd, input logic rw,
                       input logic [4:0] wa);
    valid_m = v; pc_m = pc; alu_m = alu; dm_rdata_m = dm; hit_dm_m = hit;
    br_rdata_m = br; loadsel_m = ls; wdsel_m = wd; regwr_m = rw; waddr_m = wa;
  endtask

  initial begin
    reset = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
    set_m(1'b1, 32'h1234_0000, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 32'h0, 3'd0, 2'd0, 1'b1, 5'd3);
    #1;
    cyc(); cyc(); cyc();
    // 1: reset state
    check("rst_valid", {31'd0, valid_w}, 32'd0);
    check("rst_pc", pc_w, 32'h0000_3000);
    check("rst_regwr", {31'd0, regwr_w}, 32'd0);
    check("rst_wdata", wdata_w, 32'd0);
    check("rst_instret", instret_w, 32'd0);
    reset = 1'b0;

    // 2: lb / lbu from data memory, byte lane 2
    set_m(1'b1, 32'h0000_3000, 32'h0000_0106, 32'h12F4_5678, 1'b1, 32'hDEAD_BEEF, 3'd2, 2'd1, 1'b1, 5'd8);
    cyc();
    check("lb_wdata", wdata_w, 32'hFFFF_FFF4);
    check("lb_regwr", {31'd0, regwr_w}, 32'd1);
    check("lb_waddr", {27'd0, waddr_w}, 32'd8);
    check("lb_pc", pc_w, 32'h0000_3000);
    loadsel_m = 3'd1; pc_m = 32'h0000_3004;
    cyc();
    check("lbu_wdata", wdata_w, 32'h0000_00F4);
    check("instret_1", instret_w, 32'd1);

    // 3: lh / lhu from bridge
    set_m(1'b1, 32'h0000_3008, 32'h0000_2002, 32'h0BAD_0BAD, 1'b0, 32'h8001_7FFF, 3'd4, 2'd1, 1'b1, 5'd9);
    cyc();
    check("lh_hi_wdata", wdata_w, 32'hFFFF_8001);
    set_m(1'b1, 32'h0000_300C, 32'h0000_2001, 32'h0BAD_0BAD, 1'b0, 32'h8001_7FFF, 3'd3, 2'd1, 1'b1, 5'd9);
    cyc();
    check("lhu_lo_wdata", wdata_w, 32'h0000_7FFF);

    // reserved loadsel acts as lw; wdsel 3 selects alu
    set_m(1'b1, 32'h0000_3014, 32'h0000_0003, 32'hCAFE_F00D, 1'b1, 32'h0, 3'd7, 2'd1, 1'b1, 5'd4);
    cyc();
    check("rsvd_lw_wdata", wdata_w, 32'hCAFE_F00D);
    wdsel_m = 2'd3; alu_m = 32'h7654_3210;
    cyc();
    check("wdsel3_wdata", wdata_w, 32'h7654_3210);

    // 4: jal link value, then the same to $0
    set_m(1'b1, 32'h0000_3010, 32'h0000_0000, 32'h0, 1'b1, 32'h0, 3'd0, 2'd2, 1'b1, 5'd31);
    cyc();
    check("jal_wdata", wdata_w, 32'h0000_3018);
    check("jal_regwr", {31'd0, regwr_w}, 32'd1);
    waddr_m = 5'd0;
    cyc();
    check("jal_r0_regwr", {31'd0, regwr_w}, 32'd0);
    check("jal_r0_waddr", {27'd0, waddr_w}, 32'd0);
    check("instret_7", instret_w, 32'd7);

    // 5: stall three cycles while M inputs change
    hold_pc = pc_w; hold_wdata = wdata_w; hold_waddr = waddr_w; hold_instret = instret_w;
    stall_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_m(1'b1, 32'h0000_4000 + i, 32'h1111_0000 + i, 32'h0, 1'b1, 32'h0, 3'd0, 2'd0, 1'b1, 5'd5 + 5'(i));
      cyc();
      check("stall_pc", pc_w, hold_pc);
      check("stall_wdata", wdata_w, hold_wdata);
      check("stall_waddr", {27'd0, waddr_w}, {27'd0, hold_waddr});
      check("stall_instret", instret_w, hold_instret);
    end
    flush_w = 1'b1;
    cyc();
    check("flush_valid", {31'd0, valid_w}, 32'd0);
    check("flush_regwr", {31'd0, regwr_w}, 32'd0);
    check("flush_pc", pc_w, 32'h0000_3000);
    check("flush_wdata", wdata_w, 32'd0);
    check("flush_instret", instret_w, 32'd7);
    flush_w = 1'b0;
    stall_w = 1'b0;
    cyc();
    check("post_flush_valid", {31'd0, valid_w}, 32'd1);
    check("post_flush_wdata", wdata_w, 32'h1111_0002);

    // reset during a stall clears everything
    stall_w = 1'b1; reset = 1'b1;
    cyc();
    check("rst_stall_valid", {31'd0, valid_w}, 32'd0);
    check("rst_stall_instret", instret_w, 32'd0);
    check("rst_stall_pc", pc_w, 32'h0000_3000);
    stall_w = 1'b0;
    cyc();
    reset = 1'b0;

    // 6: five back-to-back retirements
    for (int i = 0; i < 5; i++) begin
      set_m(1'b1, 32'h0000_3000 + 32'(4 * i), 32'(i), 32'h0, 1'b1, 32'h0, 3'd0, 2'd0, 1'b1, 5'd2);
      cyc();
    end
    valid_m = 1'b0;
    cyc();
    check("instret_5", instret_w, 32'd5);
    cyc();
    dut.instret_reg = 32'hFFFF_FFFF;
    #1;
    check("instret_forced", instret_w, 32'hFFFF_FFFF);
    valid_m = 1'b1;
    cyc();
    check("instret_pre_wrap", instret_w, 32'hFFFF_FFFF);
    valid_m = 1'b0;
    cyc();
    check("instret_wrap", instret_w, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
